// File: rtl/aec_pkg.sv
// Shared constants and FSM state type for the AEC front-end scheduler.
package aec_pkg;

    localparam int CHAR_W = 8;
    localparam int RES_W  = 7;

    localparam logic [CHAR_W-1:0] ASCII_EQ = 8'h3D;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_WAIT = 3'd3,
        ST_RESP = 3'd4
    } state_t;

endpackage

// File: rtl/aec_rr_arb.sv
// Combinational round-robin arbiter: searches upward from rr_ptr+1 with wrap
// and returns the first requester found as a one-hot grant and an index.
module aec_rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    // Priority search starting just after the last served requester
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/aec_sched.sv
// Scheduler sharing one arithmetic-expression evaluator among NUM_REQ
// requesters: round-robin grant, buffer the expression, replay it one
// character per cycle, wait for the result and return it tagged with the ID.
// Optional WAIT-state timeout is compiled in with `define AEC_SCHED_TIMEOUT_EN.
module aec_sched
    import aec_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_char,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [CHAR_W-1:0]          eval_ascii,
    output logic                       eval_ready,
    input  logic                       eval_valid,
    input  logic [RES_W-1:0]           eval_result,
    output logic                       resp_valid,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [RES_W-1:0]           resp_result,
    output logic                       resp_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int PTR_W = $clog2(MAX_LEN);

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [LEN_W-1:0]   len;
    logic [PTR_W-1:0]   idx;
    logic [CHAR_W-1:0]  char_buf [MAX_LEN];
    logic [RES_W-1:0]   result_q;
    logic               err_q;
    logic [CHAR_W-1:0]  cur_char;
    logic               accept;
`ifdef AEC_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]   wait_cnt;
`endif

    aec_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req     (req_valid),
        .rr_ptr  (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Granted requester's character and the LOAD handshake
    always_comb begin
        cur_char = req_char[{gnt_idx, 3'b000} +: CHAR_W];
        accept   = (state == ST_LOAD) && req_valid[gnt_idx];
    end

    // Outputs decode from registered state so they are all zero out of reset
    assign req_ready   = (state == ST_LOAD) ? gnt : '0;
    assign eval_ready  = (state == ST_SEND);
    assign eval_ascii  = eval_ready ? char_buf[idx] : '0;
    assign resp_valid  = (state == ST_RESP);
    assign resp_id     = resp_valid ? gnt_idx  : '0;
    assign resp_result = resp_valid ? result_q : '0;
    assign resp_err    = resp_valid ? err_q    : 1'b0;

    // Expression buffer: data only, no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            char_buf[len[PTR_W-1:0]] <= cur_char;
        end
    end

    // Control FSM: arbitration, capture, replay, result wait, response
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= IDX_W'(NUM_REQ - 1);
            gnt      <= '0;
            gnt_idx  <= '0;
            len      <= '0;
            idx      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
`ifdef AEC_SCHED_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        gnt     <= arb_gnt;
                        gnt_idx <= arb_idx;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        len <= len + 1'b1;
                        if (cur_char == ASCII_EQ) begin
                            state <= ST_SEND;
                        end else if (len == LEN_W'(MAX_LEN - 1)) begin
                            // Buffer full without '=': reject, evaluator untouched
                            result_q <= '0;
                            err_q    <= 1'b1;
                            state    <= ST_RESP;
                        end
                    end
                end
                ST_SEND: begin
                    if (LEN_W'(idx) == len - LEN_W'(1)) begin
                        idx   <= '0;
                        state <= ST_WAIT;
`ifdef AEC_SCHED_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (eval_valid) begin
                        result_q <= eval_result;
                        err_q    <= 1'b0;
                        state    <= ST_RESP;
                    end
`ifdef AEC_SCHED_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                        state    <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    rr_ptr <= gnt_idx;
                    gnt    <= '0;
                    len    <= '0;
                    idx    <= '0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aec_sched.sv
// Self-checking bench for aec_sched: requester drivers, a behavioural
// evaluator that answers from a queue of expected results, and monitors.
module tb_aec_sched;

    localparam int NUM_REQ = 2;
    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 10;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [8*NUM_REQ-1:0] req_char = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           eval_ascii;
    logic                 eval_ready;
    logic                 eval_valid;
    logic [6:0]           eval_result;
    logic                 resp_valid;
    logic [0:0]           resp_id;
    logic [6:0]           resp_result;
    logic                 resp_err;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    byte ch_q[$];
    int  cy_q[$];
    int  rid_q[$];
    int  rres_q[$];
    int  rerr_q[$];
    int  rcy_q[$];
    int  model_q[$];
    int  model_delay = 1;

    aec_sched #(.NUM_REQ(NUM_REQ), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_char(req_char),
        .req_ready(req_ready), .eval_ascii(eval_ascii), .eval_ready(eval_ready),
        .eval_valid(eval_valid), .eval_result(eval_result), .resp_valid(resp_valid),
        .resp_id(resp_id), .resp_result(resp_result), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitors: evaluator-side characters and responses
    always @(negedge clk) begin
        if (eval_ready === 1'b1) begin
            ch_q.push_back(eval_ascii);
            cy_q.push_back(cyc);
        end
        if (resp_valid === 1'b1) begin
            rid_q.push_back(int'(resp_id));
            rres_q.push_back(int'(resp_result));
            rerr_q.push_back(int'(resp_err));
            rcy_q.push_back(cyc);
        end
    end

    // Evaluator model: after seeing '=', answer with the next queued result
    initial begin
        int r;
        eval_valid  = 1'b0;
        eval_result = '0;
        forever begin
            @(negedge clk);
            if (eval_ready === 1'b1 && eval_ascii == 8'h3D && model_q.size() > 0) begin
                r = model_q.pop_front();
                repeat (model_delay) @(negedge clk);
                eval_result = 7'(r);
                eval_valid  = 1'b1;
                @(negedge clk);
                eval_valid  = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic clear_mon();
        ch_q.delete(); cy_q.delete(); rid_q.delete();
        rres_q.delete(); rerr_q.delete(); rcy_q.delete();
    endtask

    task automatic drive_expr(input int id, input string s, input int bubbles);
        int g;
        for (int i = 0; i < s.len(); i++) begin
            req_valid[id]       = 1'b1;
            req_char[id*8 +: 8] = s[i];
            g = 0;
            while (req_ready[id] !== 1'b1 && g < 400) begin
                @(negedge clk);
                g++;
            end
            if (g >= 400) begin
                n_checks++; n_fails++;
                $display("FAIL drive_accept req%0d char %0d: req_ready stayed 0, required 1", id, i);
                req_valid[id] = 1'b0;
                return;
            end
            @(negedge clk);
            req_valid[id] = 1'b0;
            if (i < s.len() - 1) repeat (bubbles) @(negedge clk);
        end
    endtask

    task automatic wait_resps(input int n, input int limit, output bit ok);
        int g;
        g = 0;
        while (rid_q.size() < n && g < limit) begin
            @(negedge clk);
            g++;
        end
        repeat (2) @(negedge clk);
        ok = (rid_q.size() >= n);
    endtask

    function automatic string gen_expr(output int val);
        int a, b, op;
        a  = $urandom_range(0, 99);
        b  = $urandom_range(0, 99);
        op = $urandom_range(0, 2);
        case (op)
            0:       begin gen_expr = $sformatf("%0d+%0d=", a, b); val = (a + b) & 127; end
            1:       begin gen_expr = $sformatf("%0d-%0d=", a, b); val = (a - b) & 127; end
            default: begin gen_expr = $sformatf("%0d*%0d=", a, b); val = (a * b) & 127; end
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        repeat (3) @(negedge clk);
        n_checks++; if (req_ready !== '0) begin n_fails++; $display("FAIL reset_req_ready: got %b required 0", req_ready); end
        n_checks++; if (eval_ready !== 1'b0) begin n_fails++; $display("FAIL reset_eval_ready: got %b required 0", eval_ready); end
        n_checks++; if (eval_ascii !== 8'h00) begin n_fails++; $display("FAIL reset_eval_ascii: got %h required 00", eval_ascii); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fails++; $display("FAIL reset_resp_valid: got %b required 0", resp_valid); end
        n_checks++; if ({resp_id, resp_result, resp_err} !== '0) begin n_fails++; $display("FAIL reset_resp_fields: got %h/%h/%b required 0", resp_id, resp_result, resp_err); end
        req_valid = '0;
        rst = 1'b0;
        @(negedge clk);
        clear_mon();
    endtask

    task automatic test_single();
        bit ok;
        string s;
        s = "3+4=";
        clear_mon();
        model_q.push_back(7);
        drive_expr(0, s, 0);
        wait_resps(1, 200, ok);
        n_checks++; if (!ok) begin n_fails++; $display("FAIL single_resp: got none required 1 response"); end
        if (ok) begin
            n_checks++; if (ch_q.size() != 4) begin n_fails++; $display("FAIL single_nchars: got %0d required 4", ch_q.size()); end
            for (int k = 0; k < ch_q.size() && k < 4; k++) begin
                n_checks++; if (ch_q[k] != s[k]) begin n_fails++; $display("FAIL single_char%0d: got %h required %h", k, ch_q[k], s[k]); end
            end
            n_checks++; if (cy_q[cy_q.size()-1] - cy_q[0] != 3) begin n_fails++; $display("FAIL single_gapfree: span %0d required 3", cy_q[cy_q.size()-1] - cy_q[0]); end
            n_checks++; if (rid_q[0] != 0 || rres_q[0] != 7 || rerr_q[0] != 0) begin n_fails++; $display("FAIL single_resp_fields: got id%0d res%0d err%0d required id0 res7 err0", rid_q[0], rres_q[0], rerr_q[0]); end
            repeat (3) @(negedge clk);
            n_checks++; if (rid_q.size() != 1) begin n_fails++; $display("FAIL single_pulse_count: got %0d required 1", rid_q.size()); end
        end
    endtask

    task automatic test_contention();
        bit ok;
        string s0, s1, s2, all;
        int v0, v1, v2;
        int exp_id[3];
        int exp_res[3];
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        clear_mon();
        s0 = gen_expr(v0); s1 = gen_expr(v1); s2 = gen_expr(v2);
        model_q.push_back(v0); model_q.push_back(v1); model_q.push_back(v2);
        exp_id  = '{0, 1, 0};
        exp_res = '{v0, v1, v2};
        fork
            begin drive_expr(0, s0, 0); drive_expr(0, s2, 0); end
            begin drive_expr(1, s1, 0); end
        join
        wait_resps(3, 400, ok);
        n_checks++; if (!ok) begin n_fails++; $display("FAIL contention_resp: got %0d required 3 responses", rid_q.size()); end
        if (ok) begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (rid_q[k] != exp_id[k] || rres_q[k] != exp_res[k] || rerr_q[k] != 0) begin
                    n_fails++;
                    $display("FAIL contention_resp%0d: got id%0d res%0d err%0d required id%0d res%0d err0", k, rid_q[k], rres_q[k], rerr_q[k], exp_id[k], exp_res[k]);
                end
            end
            all = {s0, s1, s2};
            n_checks++; if (ch_q.size() != all.len()) begin n_fails++; $display("FAIL contention_nchars: got %0d required %0d", ch_q.size(), all.len()); end
            for (int k = 0; k < ch_q.size() && k < all.len(); k++) begin
                n_checks++; if (ch_q[k] != all[k]) begin n_fails++; $display("FAIL contention_char%0d: got %h required %h", k, ch_q[k], all[k]); end
            end
        end
    endtask

    task automatic test_bubbles();
        bit ok;
        string s;
        s = "(2+3)*4=";
        clear_mon();
        model_q.push_back(20);
        drive_expr(1, s, 2);
        wait_resps(1, 300, ok);
        n_checks++; if (!ok) begin n_fails++; $display("FAIL bubbles_resp: got none required 1 response"); end
        if (ok) begin
            n_checks++; if (ch_q.size() != 8) begin n_fails++; $display("FAIL bubbles_nchars: got %0d required 8", ch_q.size()); end
            for (int k = 0; k < ch_q.size() && k < 8; k++) begin
                n_checks++; if (ch_q[k] != s[k] || cy_q[k] != cy_q[0] + k) begin n_fails++; $display("FAIL bubbles_char%0d: got %h at +%0d required %h at +%0d", k, ch_q[k], cy_q[k] - cy_q[0], s[k], k); end
            end
            n_checks++; if (rid_q[0] != 1 || rres_q[0] != 20 || rerr_q[0] != 0) begin n_fails++; $display("FAIL bubbles_resp_fields: got id%0d res%0d err%0d required id1 res20 err0", rid_q[0], rres_q[0], rerr_q[0]); end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        string ov, full, s1;
        int vf, v1;
        clear_mon();
        ov = "";
        for (int i = 0; i < MAX_LEN; i++) ov = {ov, $sformatf("%0d", $urandom_range(0, 9))};
        full = "";
        for (int i = 0; i < MAX_LEN - 1; i++) full = {full, $sformatf("%0d", $urandom_range(0, 9))};
        full = {full, "="};
        vf = $urandom_range(0, 127);
        s1 = gen_expr(v1);
        drive_expr(0, ov, $urandom_range(0, 1));
        model_q.push_back(vf);
        drive_expr(0, full, 0);
        model_q.push_back(v1);
        drive_expr(1, s1, 0);
        wait_resps(3, 400, ok);
        n_checks++; if (!ok) begin n_fails++; $display("FAIL overflow_resp: got %0d required 3 responses", rid_q.size()); end
        if (ok) begin
            n_checks++; if (rid_q[0] != 0 || rres_q[0] != 0 || rerr_q[0] != 1) begin n_fails++; $display("FAIL overflow_err: got id%0d res%0d err%0d required id0 res0 err1", rid_q[0], rres_q[0], rerr_q[0]); end
            n_checks++; if (rid_q[1] != 0 || rres_q[1] != vf || rerr_q[1] != 0) begin n_fails++; $display("FAIL overflow_full16: got id%0d res%0d err%0d required id0 res%0d err0", rid_q[1], rres_q[1], rerr_q[1], vf); end
            n_checks++; if (rid_q[2] != 1 || rres_q[2] != v1 || rerr_q[2] != 0) begin n_fails++; $display("FAIL overflow_next: got id%0d res%0d err%0d required id1 res%0d err0", rid_q[2], rres_q[2], rerr_q[2], v1); end
            n_checks++; if (ch_q.size() != MAX_LEN + s1.len()) begin n_fails++; $display("FAIL overflow_nchars: got %0d required %0d", ch_q.size(), MAX_LEN + s1.len()); end
            if (ch_q.size() > 0) begin
                n_checks++; if (ch_q[0] != full[0]) begin n_fails++; $display("FAIL overflow_first_char: got %h required %h", ch_q[0], full[0]); end
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        string s;
        int v, id;
        for (int t = 0; t < 8; t++) begin
            clear_mon();
            id = $urandom_range(0, NUM_REQ - 1);
            s = gen_expr(v);
            model_delay = $urandom_range(1, 6);
            model_q.push_back(v);
            drive_expr(id, s, $urandom_range(0, 2));
            wait_resps(1, 300, ok);
            n_checks++; if (!ok) begin n_fails++; $display("FAIL random%0d_resp: got none required 1 response", t); end
            if (ok) begin
                n_checks++; if (rid_q[0] != id || rres_q[0] != v || rerr_q[0] != 0) begin n_fails++; $display("FAIL random%0d_fields: got id%0d res%0d err%0d required id%0d res%0d err0", t, rid_q[0], rres_q[0], rerr_q[0], id, v); end
                n_checks++; if (ch_q.size() != s.len() || cy_q[cy_q.size()-1] - cy_q[0] != s.len() - 1) begin n_fails++; $display("FAIL random%0d_replay: got %0d chars required %0d gap-free", t, ch_q.size(), s.len()); end
            end
        end
        model_delay = 1;
    endtask

    task automatic test_timeout();
        bit ok;
`ifdef AEC_SCHED_TIMEOUT_EN
        int eq_cyc;
        clear_mon();
        drive_expr(0, "8+1=", 0);
        wait_resps(1, 100, ok);
        n_checks++; if (!ok) begin n_fails++; $display("FAIL timeout_resp: got none required 1 response"); end
        if (ok) begin
            eq_cyc = cy_q[cy_q.size()-1];
            n_checks++; if (rcy_q[0] != eq_cyc + 1 + TIMEOUT) begin n_fails++; $display("FAIL timeout_latency: got %0d cycles after WAIT entry required %0d", rcy_q[0] - eq_cyc - 1, TIMEOUT); end
            n_checks++; if (rerr_q[0] != 1 || rres_q[0] != 0 || rid_q[0] != 0) begin n_fails++; $display("FAIL timeout_fields: got id%0d res%0d err%0d required id0 res0 err1", rid_q[0], rres_q[0], rerr_q[0]); end
        end
        clear_mon();
        model_delay = TIMEOUT;
        model_q.push_back(9);
        drive_expr(1, "4+5=", 0);
        wait_resps(1, 100, ok);
        n_checks++; if (!ok || rid_q[0] != 1 || rres_q[0] != 9 || rerr_q[0] != 0) begin n_fails++; $display("FAIL timeout_limit_race: got %0d resp res%0d err%0d required res9 err0", rid_q.size(), ok ? rres_q[0] : -1, ok ? rerr_q[0] : -1); end
        model_delay = 1;
`else
        clear_mon();
        drive_expr(0, "8+1=", 0);
        repeat (1000) @(negedge clk);
        ok = (rid_q.size() == 0);
        n_checks++; if (!ok) begin n_fails++; $display("FAIL wait_hold_resp: got %0d responses required 0", rid_q.size()); end
        n_checks++; if (eval_ready !== 1'b0 || req_ready !== '0 || resp_valid !== 1'b0) begin n_fails++; $display("FAIL wait_hold_outputs: got eval_ready %b req_ready %b resp_valid %b required 0", eval_ready, req_ready, resp_valid); end
        rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
`endif
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        int n, g;
        clear_mon();
        drive_expr(0, "12+34=", 0);
        n = 0; g = 0;
        while (g < 100) begin
            if (eval_ready === 1'b1) begin
                n++;
                if (n == 3) break;
            end
            @(negedge clk);
            g++;
        end
        n_checks++; if (n != 3) begin n_fails++; $display("FAIL midsend_reach_idx2: got %0d chars required 3", n); end
        n_checks++; if (eval_ascii !== 8'h2B) begin n_fails++; $display("FAIL midsend_idx2_char: got %h required 2b", eval_ascii); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (eval_ready !== 1'b0 || eval_ascii !== 8'h00 || resp_valid !== 1'b0 || req_ready !== '0) begin n_fails++; $display("FAIL midsend_reset_outputs: got %b/%h/%b/%b required all 0", eval_ready, eval_ascii, resp_valid, req_ready); end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++; if (rid_q.size() != 0) begin n_fails++; $display("FAIL midsend_no_resp: got %0d responses required 0", rid_q.size()); end
        clear_mon();
        model_q.push_back(2);
        drive_expr(1, "1+1=", 0);
        wait_resps(1, 200, ok);
        n_checks++; if (!ok || rid_q[0] != 1 || rres_q[0] != 2 || rerr_q[0] != 0) begin n_fails++; $display("FAIL midsend_recover: got %0d resp id%0d res%0d required id1 res2 err0", rid_q.size(), ok ? rid_q[0] : -1, ok ? rres_q[0] : -1); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_bubbles();
        test_overflow();
        test_random();
        test_timeout();
        test_reset_mid_send();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
